// File: rtl/uart_word_tx_if.sv
// Handshake and serial-output bundle for uart_word_tx: word request in,
// serial line plus progress/status out.
interface uart_word_tx_if;
  logic        Start;
  logic [31:0] Data_32;
  logic        Tx;
  logic        Busy;
  logic        Done;
  logic [1:0]  Byte_idx;

  modport master (
    output Start, Data_32,
    input  Tx, Busy, Done, Byte_idx
  );

  modport slave (
    input  Start, Data_32,
    output Tx, Busy, Done, Byte_idx
  );
endinterface

// File: rtl/uart_word_tx.sv
// 32-bit word UART transmitter: one handshake, four back-to-back 8N1 frames,
// LSB-first bits, byte order selectable; bit timing from a cycle counter.
module uart_word_tx #(
  parameter int CLKS_PER_BIT   = 5208,
  parameter bit LSB_BYTE_FIRST = 1'b1
) (
  input  logic           Clk,
  input  logic           Rst,
  uart_word_tx_if.slave  bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       byte_q, byte_d;
  logic [31:0]      word_q, word_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [1:0]       sel;
  logic [7:0]       cur_byte;

  // Byte_idx counts in transmission order; MSB-first order maps idx to 3-idx.
  assign sel      = LSB_BYTE_FIRST ? byte_q : ~byte_q;
  assign cur_byte = word_q[{sel, 3'b000} +: 8];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    word_d  = word_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (bus.Start) begin
          word_d  = bus.Data_32;
          byte_d  = 2'd0;
          cnt_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = DATA;
          tx_d    = cur_byte[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (byte_q == 2'd3) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // Next start bit follows the stop bit with no gap.
            byte_d  = byte_q + 2'd1;
            state_d = START;
            tx_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.Tx       = tx_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.Byte_idx = byte_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: two instances (N=4 LSB-byte-first,
// N=2 MSB-byte-first), a timeline reference model and a UART receiver model.
module tb_uart_word_tx;

  localparam int N0 = 4;
  localparam int N1 = 2;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [31:0] data  = '0;

  always #5 clk = ~clk;

  uart_word_tx_if bus0();
  uart_word_tx_if bus1();

  assign bus0.Start   = start;
  assign bus0.Data_32 = data;
  assign bus1.Start   = start;
  assign bus1.Data_32 = data;

  uart_word_tx #(.CLKS_PER_BIT(N0), .LSB_BYTE_FIRST(1'b1)) u_dut0 (
    .Clk (clk),
    .Rst (rst),
    .bus (bus0)
  );

  uart_word_tx #(.CLKS_PER_BIT(N1), .LSB_BYTE_FIRST(1'b0)) u_dut1 (
    .Clk (clk),
    .Rst (rst),
    .bus (bus1)
  );

  logic       otx   [2];
  logic       obusy [2];
  logic       odone [2];
  logic [1:0] oidx  [2];

  always_comb begin
    otx[0] = bus0.Tx;  obusy[0] = bus0.Busy; odone[0] = bus0.Done; oidx[0] = bus0.Byte_idx;
    otx[1] = bus1.Tx;  obusy[1] = bus1.Busy; odone[1] = bus1.Done; oidx[1] = bus1.Byte_idx;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: position in the 40*N-cycle timeline ----
  int          nn  [2] = '{N0, N1};
  bit          lsb [2] = '{1'b1, 1'b0};
  int          t   [2] = '{0, 0};   // 0 idle, 1..40N busy, 40N+1 Done cycle
  logic [31:0] w   [2];
  int          cyc = 0;

  function automatic logic [7:0] model_byte(input logic [31:0] ww, input int k, input bit lb);
    int pos;
    pos = lb ? k : 3 - k;
    return ww[8*pos +: 8];
  endfunction

  function automatic logic model_tx(input int tt, input logic [31:0] ww, input int n, input bit lb);
    int k, pos;
    logic [7:0] b;
    if (tt < 1 || tt > 40*n) return 1'b1;
    k   = (tt - 1) / (10*n);
    pos = ((tt - 1) % (10*n)) / n;
    b   = model_byte(ww, k, lb);
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (rst)
        t[i] = 0;
      else if ((t[i] == 0 || t[i] == 40*nn[i] + 1) && start) begin
        t[i] = 1;
        w[i] = data;
      end else if (t[i] != 0 && t[i] <= 40*nn[i])
        t[i] = t[i] + 1;
      else
        t[i] = 0;
    end
  end

  // ---------------- per-cycle compare + receiver model + counters ----------
  logic [7:0] rxq0[$];
  logic [7:0] rxq1[$];
  bit         rx_act  [2] = '{1'b0, 1'b0};
  int         rx_cnt  [2] = '{0, 0};
  logic [7:0] rx_sh   [2];
  logic       rx_prev [2] = '{1'b1, 1'b1};
  int         ferr     [2] = '{0, 0};
  int         busy_cnt [2] = '{0, 0};
  int         done_cnt [2] = '{0, 0};
  int         done_cyc [2] = '{0, 0};

  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      for (int i = 0; i < 2; i++) begin
        int n;
        int h;
        n = nn[i];
        h = n / 2;
        check($sformatf("tx%0d", i),   32'(otx[i]),   32'(model_tx(t[i], w[i], n, lsb[i])));
        check($sformatf("busy%0d", i), 32'(obusy[i]), 32'(t[i] >= 1 && t[i] <= 40*n));
        check($sformatf("done%0d", i), 32'(odone[i]), 32'(t[i] == 40*n + 1));
        if (t[i] >= 1 && t[i] <= 40*n)
          check($sformatf("byte_idx%0d", i), 32'(oidx[i]), 32'((t[i] - 1) / (10*n)));

        busy_cnt[i] += int'(obusy[i]);
        if (odone[i] === 1'b1) begin
          done_cnt[i]++;
          done_cyc[i] = cyc;
        end

        if (rst) begin
          rx_act[i]  = 1'b0;
          rx_prev[i] = 1'b1;
        end else begin
          if (!rx_act[i]) begin
            if (rx_prev[i] && !otx[i]) begin
              rx_act[i] = 1'b1;
              rx_cnt[i] = 0;
            end
          end else
            rx_cnt[i]++;
          if (rx_act[i]) begin
            if (rx_cnt[i] == h && otx[i]) begin
              rx_act[i] = 1'b0;
              ferr[i]++;
            end else if (rx_cnt[i] >= h + n && rx_cnt[i] <= h + 8*n && (rx_cnt[i] - h) % n == 0)
              rx_sh[i][(rx_cnt[i] - h) / n - 1] = otx[i];
            else if (rx_cnt[i] == h + 9*n) begin
              if (otx[i] !== 1'b1) ferr[i]++;
              if (i == 0) rxq0.push_back(rx_sh[i]);
              else        rxq1.push_back(rx_sh[i]);
              rx_act[i] = 1'b0;
            end
          end
          rx_prev[i] = otx[i];
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while ((t[0] != 0 || t[1] != 0) && k < bound) begin
      tick(1);
      k++;
    end
    check("wait_idle_timeout", 32'(k >= bound), 32'd0);
  endtask

  int c0, b0, b1, d0, d1, f0, f1, k;

  initial begin
    rst = 1'b1;
    tick(3);
    check("rst_tx0",   32'(otx[0]),   32'd1);
    check("rst_busy0", 32'(obusy[0]), 32'd0);
    check("rst_done0", 32'(odone[0]), 32'd0);
    check("rst_idx0",  32'(oidx[0]),  32'd0);
    check("rst_tx1",   32'(otx[1]),   32'd1);
    check("rst_busy1", 32'(obusy[1]), 32'd0);
    rst = 1'b0;
    tick(2);

    // Basic word, Start while busy, Data_32 changes mid-frame
    rxq0.delete(); rxq1.delete();
    b0 = busy_cnt[0]; b1 = busy_cnt[1]; d0 = done_cnt[0]; d1 = done_cnt[1];
    f0 = ferr[0]; f1 = ferr[1];
    c0 = cyc;
    start = 1'b1; data = 32'h8292AABA;
    tick(1);
    start = 1'b0; data = $urandom;
    tick(47);
    start = 1'b1; data = 32'h11223344;
    tick(1);
    start = 1'b0;
    repeat (10) begin
      data = $urandom;
      tick(7);
    end
    wait_idle(400);
    check("busy_len0",  32'(busy_cnt[0] - b0), 32'd160);
    check("busy_len1",  32'(busy_cnt[1] - b1), 32'd80);
    check("done_once0", 32'(done_cnt[0] - d0), 32'd1);
    check("done_once1", 32'(done_cnt[1] - d1), 32'd1);
    check("done_cyc0",  32'(done_cyc[0] - c0), 32'd161);
    check("done_cyc1",  32'(done_cyc[1] - c0), 32'd81);
    check("rx0_size", 32'(rxq0.size()), 32'd4);
    check("rx0_b0", 32'(rxq0[0]), 32'hBA);
    check("rx0_b1", 32'(rxq0[1]), 32'hAA);
    check("rx0_b2", 32'(rxq0[2]), 32'h92);
    check("rx0_b3", 32'(rxq0[3]), 32'h82);
    check("rx1_size", 32'(rxq1.size()), 32'd4);
    check("rx1_b0", 32'(rxq1[0]), 32'h82);
    check("rx1_b1", 32'(rxq1[1]), 32'h92);
    check("rx1_b2", 32'(rxq1[2]), 32'hAA);
    check("rx1_b3", 32'(rxq1[3]), 32'hBA);
    check("ferr0", 32'(ferr[0] - f0), 32'd0);
    check("ferr1", 32'(ferr[1] - f1), 32'd0);

    // Back-to-back: Start held high, FFFFFFFF then 00000000
    rxq0.delete(); rxq1.delete();
    f0 = ferr[0]; f1 = ferr[1];
    start = 1'b1; data = 32'hFFFFFFFF;
    tick(1);
    data = 32'h00000000;
    k = 0;
    while (odone[0] !== 1'b1 && k < 300) begin
      tick(1);
      k++;
    end
    check("b2b_done_timeout", 32'(k >= 300), 32'd0);
    check("b2b_idle_high", 32'(otx[0]), 32'd1);
    tick(1);
    check("b2b_start_low", 32'(otx[0]),   32'd0);
    check("b2b_busy_again", 32'(obusy[0]), 32'd1);
    start = 1'b0;
    wait_idle(400);
    check("b2b_rx0_size", 32'(rxq0.size()), 32'd8);
    check("b2b_rx1_size", 32'(rxq1.size()), 32'd8);
    for (int j = 0; j < 8; j++) begin
      check($sformatf("b2b_rx0_%0d", j), 32'(rxq0[j]), (j < 4) ? 32'hFF : 32'h00);
      check($sformatf("b2b_rx1_%0d", j), 32'(rxq1[j]), (j < 4) ? 32'hFF : 32'h00);
    end
    check("b2b_ferr0", 32'(ferr[0] - f0), 32'd0);
    check("b2b_ferr1", 32'(ferr[1] - f1), 32'd0);

    // Reset during byte 2, data bit 3 of the N=4 instance (cycle 97)
    tick(3);
    d0 = done_cnt[0];
    c0 = cyc;
    start = 1'b1; data = 32'h8292AABA;
    tick(1);
    start = 1'b0;
    tick(96);
    rst = 1'b1;
    tick(1);
    check("mid_rst_tx0",   32'(otx[0]),   32'd1);
    check("mid_rst_busy0", 32'(obusy[0]), 32'd0);
    check("mid_rst_idx0",  32'(oidx[0]),  32'd0);
    check("mid_rst_done0", 32'(odone[0]), 32'd0);
    rst = 1'b0;
    tick(3);
    check("mid_rst_no_done", 32'(done_cnt[0] - d0), 32'd0);
    rxq0.delete(); rxq1.delete();
    start = 1'b1; data = 32'hC3A51E7F;
    tick(1);
    start = 1'b0;
    wait_idle(400);
    check("post_rst_done", 32'(done_cnt[0] - d0), 32'd1);
    check("post_rst_rx0_size", 32'(rxq0.size()), 32'd4);
    check("post_rst_rx0_b0", 32'(rxq0[0]), 32'h7F);
    check("post_rst_rx0_b3", 32'(rxq0[3]), 32'hC3);
    check("post_rst_rx1_b0", 32'(rxq1[0]), 32'hC3);
    check("post_rst_rx1_b3", 32'(rxq1[3]), 32'h7F);

    // Randomized traffic: sparse Start pulses, noisy data, rare resets
    repeat (4000) begin
      start = ($urandom_range(0, 11) == 0);
      data  = $urandom;
      rst   = ($urandom_range(0, 599) == 0);
      tick(1);
    end
    start = 1'b0;
    rst   = 1'b0;
    wait_idle(400);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
